// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in, serial-out shifter. A word offered on the load handshake is
//   captured in IDLE, then presented one bit at a time on data_out; each rising
//   edge with ena=1 consumes the current bit. done pulses for one cycle after
//   the final bit has been consumed.
//
// Parameters
//   N          word width in bits (>= 2)
//   MSB_FIRST  1: load_data[N-1] goes out first; 0: load_data[0] goes out first
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   ena         bit strobe; consumes the current bit while out_valid=1
//   load_valid  load_data is offered
//   load_data   word to serialize
//   load_ready  a word can be accepted this cycle (IDLE and not in reset)
//   data_out    current serial bit (0 when no live bit)
//   out_valid   data_out carries a live bit
//   busy        word in flight (state != IDLE)
//   done        one-cycle pulse after the final bit is consumed
//
// Optional feature (compile-time macro PISO_PARITY_EN)
//   When defined, the even parity of the loaded word is appended as an extra
//   serial bit through a PARITY state, so a word takes N+1 enabled edges.
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int N         = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         load_valid,
  input  logic [N-1:0] load_data,
  output logic         load_ready,
  output logic         data_out,
  output logic         out_valid,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
`endif

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  sreg;
  logic [N-1:0]  sreg_shifted;
  logic [CW-1:0] count;
  logic          head_bit;
  logic          load_en;
  logic          shift_en;
  logic          finish;

`ifdef PISO_PARITY_EN
  logic          parity;
`endif

  // The bit on the wire always sits at the output end of the register; shifting
  // moves the next bit into that position and zero-fills the far end.
  assign head_bit     = (MSB_FIRST != 0) ? sreg[N-1] : sreg[0];
  assign sreg_shifted = (MSB_FIRST != 0) ? {sreg[N-2:0], 1'b0} : {1'b0, sreg[N-1:1]};

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    out_valid  = 1'b0;
    data_out   = 1'b0;
    load_en    = 1'b0;
    shift_en   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        // Ready is masked while reset is held so nothing upstream sees a
        // handshake that the register cannot honour.
        load_ready = ~rst;
        if (load_valid) begin
          load_en   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        data_out  = head_bit;
        if (ena) begin
          shift_en = 1'b1;
          if (count == LAST) begin
`ifdef PISO_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = IDLE;
            finish    = 1'b1;
`endif
          end
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        out_valid = 1'b1;
        data_out  = parity;
        if (ena) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg   <= '0;
      count  <= '0;
      done   <= 1'b0;
`ifdef PISO_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      done <= finish;
      if (load_en) begin
        sreg   <= load_data;
        count  <= '0;
`ifdef PISO_PARITY_EN
        parity <= ^load_data;
`endif
      end else if (shift_en) begin
        sreg <= sreg_shifted;
        // Saturate at the last index so the counter never wraps inside a word.
        if (count != LAST) begin
          count <= count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Self-checking bench for piso_serializer (N=8). An MSB-first instance is
//   tracked by a scoreboard queue of expected serial bits; an LSB-first
//   instance is exercised directly. A small SIPO model receives the MSB-first
//   stream on the shared ena strobe. Define PISO_PARITY_EN for both files to
//   cover the parity build.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int N = 8;
`ifdef PISO_PARITY_EN
  localparam int WB = N + 1;
`else
  localparam int WB = N;
`endif

  logic         clk;
  logic         rst;
  logic         ena;
  logic         load_valid;
  logic [N-1:0] load_data;
  logic         load_ready;
  logic         data_out;
  logic         out_valid;
  logic         busy;
  logic         done;

  logic         load_valid_l;
  logic [N-1:0] load_data_l;
  logic         load_ready_l;
  logic         data_out_l;
  logic         out_valid_l;
  logic         busy_l;
  logic         done_l;

  logic [N-1:0] sipo_q;
  logic         sipo_clr;

  int checks;
  int errors;
  bit sbq[$];
  bit done_pending;
  int bits_sent;

  piso_serializer #(.N(N), .MSB_FIRST(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  piso_serializer #(.N(N), .MSB_FIRST(0)) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .load_valid (load_valid_l),
    .load_data  (load_data_l),
    .load_ready (load_ready_l),
    .data_out   (data_out_l),
    .out_valid  (out_valid_l),
    .busy       (busy_l),
    .done       (done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiving SIPO: shifts from q[0] upward on each consumed bit.
  always @(posedge clk) begin
    if (sipo_clr) sipo_q <= '0;
    else if (ena && out_valid) sipo_q <= {sipo_q[N-2:0], data_out};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_bit(input logic [N-1:0] w, input int i, input bit msb);
    if (i >= N) return ^w;
    return msb ? w[N-1-i] : w[i];
  endfunction

  // Scoreboard monitor on the MSB-first instance, sampled mid-cycle.
  initial begin
    done_pending = 1'b0;
    bits_sent    = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sbq.delete();
        done_pending = 1'b0;
        bits_sent    = 0;
      end else begin
        check("done", done, done_pending);
        done_pending = 1'b0;
        check("out_valid", out_valid, sbq.size() != 0);
        check("busy", busy, sbq.size() != 0);
        if (out_valid && sbq.size() != 0) begin
          check("data_out", data_out, sbq[0]);
          if (ena) begin
            void'(sbq.pop_front());
            bits_sent++;
            if (sbq.size() == 0) begin
              check("bits_per_word", bits_sent, WB);
              bits_sent    = 0;
              done_pending = 1'b1;
            end
          end
        end
      end
    end
  end

  // Offer a word; after acceptance push its expected bits. With hold=1 the
  // valid stays asserted carrying hold_val.
  task automatic load_word(input logic [N-1:0] w, input bit hold, input logic [N-1:0] hold_val);
    bit accepted;
    accepted = 1'b0;
    @(posedge clk);
    #1;
    load_valid = 1'b1;
    load_data  = w;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (load_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    check("load_accept", accepted, 1'b1);
    @(posedge clk);
    #1;
    if (accepted) begin
      for (int i = 0; i < WB; i++) sbq.push_back(exp_bit(w, i, 1'b1));
    end
    if (hold) load_data = hold_val;
    else load_valid = 1'b0;
    check("first_bit_valid", out_valid, 1'b1);
    check("first_bit", data_out, exp_bit(w, 0, 1'b1));
  endtask

  // Drive ena (continuous or 1,0,0 pattern) until done; bounded.
  task automatic run_word(input int mode);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      ena = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check("ready_with_done", load_ready, 1'b1);
        break;
      end
      @(posedge clk);
      #1;
    end
    check("done_seen", seen, 1'b1);
  endtask

  initial begin
    logic [N-1:0] w;
    logic [N-1:0] sipo_exp;
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    ena          = 1'b0;
    load_valid   = 1'b0;
    load_data    = '0;
    load_valid_l = 1'b0;
    load_data_l  = '0;
    sipo_clr     = 1'b1;

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    check("rst_data_out", data_out, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_load_ready", load_ready, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", load_ready, 1'b1);

    // 0xA5, continuous ena (ena already high across the load edge).
    ena = 1'b1;
    load_word(8'hA5, 1'b0, 8'h00);
    run_word(0);

    // 0xA5, ena pattern 1,0,0.
    load_word(8'hA5, 1'b0, 8'h00);
    run_word(1);

    // Loopback into the SIPO model.
    sipo_clr = 1'b1;
    @(posedge clk);
    #1 sipo_clr = 1'b0;
    w = 8'h3C;
    load_word(w, 1'b0, 8'h00);
    run_word(0);
    sipo_exp = (WB == N) ? w : {w[N-2:0], ^w};
    check("sipo_loopback", sipo_q, sipo_exp);

    // LSB-first instance, load 0x01.
    @(posedge clk);
    #1;
    load_valid_l = 1'b1;
    load_data_l  = 8'h01;
    @(negedge clk);
    check("lsb_ready", load_ready_l, 1'b1);
    @(posedge clk);
    #1 load_valid_l = 1'b0;
    ena = 1'b1;
    for (int i = 0; i < WB; i++) begin
      @(negedge clk);
      check("lsb_bit", data_out_l, exp_bit(8'h01, i, 1'b0));
      check("lsb_valid", out_valid_l, 1'b1);
    end
    @(negedge clk);
    check("lsb_done", done_l, 1'b1);
    check("lsb_idle", busy_l, 1'b0);

    // 0xFF with valid held (0x00), reset after 3 bits.
    ena = 1'b1;
    load_word(8'hFF, 1'b1, 8'h00);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_data_out", data_out, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_ready", load_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_no_done", done, 1'b0);
    check("held_ready", load_ready, 1'b1);
    @(posedge clk);
    #1;
    for (int i = 0; i < WB; i++) sbq.push_back(exp_bit(8'h00, i, 1'b1));
    load_valid = 1'b0;
    check("held_load_taken", out_valid, 1'b1);
    run_word(0);

`ifdef PISO_PARITY_EN
    load_word(8'h07, 1'b0, 8'h00);
    run_word(0);
`endif

    // A few random words, alternating ena style.
    for (int k = 0; k < 4; k++) begin
      w = N'($urandom_range(0, 255));
      load_word(w, 1'b0, 8'h00);
      run_word(k % 2);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out shifter. The transmit-side counterpart of the team's serial-in, parallel-out shift register.
- Accepts an N-bit word over a valid/ready load handshake, then emits it one bit per enabled clock on `data_out`.
- Feeds a SIPO receiver, or any single-wire bit link clocked by a shared `ena` strobe.
- With the default MSB-first order, a downstream SIPO that shifts from q[0] upward holds the original word after N strobes.

Parameters:
- N, 8: word width in bits; must be >= 2.
- MSB_FIRST, 1: 1 sends load_data[N-1] first; 0 sends load_data[0] first.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- ena  input  1  bit strobe; while out_valid=1, a rising edge with ena=1 consumes the current bit
- load_valid  input  1  load_data is offered
- load_data  input  N  word to serialize
- load_ready  output  1  block can accept a word this cycle
- data_out  output  1  current serial bit
- out_valid  output  1  data_out carries a live bit
- busy  output  1  word in flight (state != IDLE)
- done  output  1  one-cycle pulse after the final bit is consumed

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; shift register, bit counter and done cleared to 0.
  - data_out=0, out_valid=0, busy=0.
  - load_ready=0 while rst is high; it goes to 1 in the first cycle after release.
- States: IDLE, SHIFT (plus PARITY with the optional feature).
- IDLE:
  - load_ready=1, out_valid=0, data_out=0.
  - On an edge with load_valid=1: sreg<=load_data, count<=0, state<=SHIFT.
  - ena is ignored in IDLE.
- SHIFT:
  - load_ready=0, out_valid=1, busy=1.
  - data_out = sreg[N-1] if MSB_FIRST, else sreg[0]. It is driven combinationally from the register.
  - On each edge with ena=1:
    - sreg shifts toward the output end (left if MSB_FIRST, right otherwise) and zero-fills.
    - count increments.
  - With ena=0, all state holds and data_out stays stable.
- Last bit:
  - Condition: an edge with ena=1 and count==N-1.
  - state<=IDLE (or PARITY if the feature is enabled); done<=1 for exactly one cycle.
- Latency:
  - The first bit appears on data_out in the cycle after load acceptance.
  - A word takes exactly N ena-qualified edges to send.
  - The next load can be accepted, at the earliest, in the cycle done is high. That gives a 1-cycle IDLE gap between words.
- Width rules:
  - count is $clog2(N) bits.
  - Count reaches N-1 and never wraps within a word; it is re-zeroed on load.
- load_valid while busy is ignored: no data capture, no state change. The sender must hold it until load_ready.
- rst mid-word:
  - Aborts immediately (asynchronously) to the reset values above.
  - No done pulse; partial bits are discarded.
- ena held at 1 across the IDLE->SHIFT edge has no effect on the load edge; shifting begins on the following edge.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - At load, even parity of load_data (XOR of all bits) is captured in a register.
  - After the Nth bit the FSM enters PARITY, with out_valid=1 and data_out=parity.
  - The next ena edge returns the FSM to IDLE and pulses done.
  - A word then takes N+1 enabled edges, and busy covers the PARITY state.
- Undefined: no PARITY state and no parity register. Behaviour is exactly as above.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge -> outputs immediately at data_out=0, out_valid=0, busy=0, done=0, load_ready=0; after release load_ready=1.
- MSB_FIRST=1, N=8, load 0xA5, ena=1 continuously -> data_out sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles, done high the cycle after the 8th bit, load_ready=1 in that same cycle.
- Same word, ena toggling 1,0,0,1,... -> identical bit sequence; each bit held stable while ena=0; exactly 8 ena-high edges before done.
- MSB_FIRST=0, load 0x01 -> first bit 1, then seven 0s.
- Loopback: serializer output into an 8-bit SIPO on the same ena; load 0x3C -> after done, SIPO q=0x3C.
- Load 0xFF, hold load_valid=1 with 0x00 after acceptance, assert rst after 3 bits -> all state cleared, no done; after release the 0x00 load is accepted. Under PISO_PARITY_EN, load 0x07 -> 8 data bits then parity bit 1, done after the 9th edge.
